// File: rtl/io_mem_loader_pkg.sv
// Shared types and widths for the IO-side memory loader/dumper.
// Also holds the start-range check used when a transfer is requested.
package io_mem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_HI = 3'd1,
        LD_LO = 3'd2,
        LD_WR = 3'd3,
        DP_RD = 3'd4,
        DP_HI = 3'd5,
        DP_LO = 3'd6,
        FIN   = 3'd7
    } state_t;

    // 17-bit sum so BASE+LEN cannot wrap before the compare.
    function automatic logic range_bad(input logic [WORD_W-1:0] base,
                                       input logic [WORD_W-1:0] len,
                                       input logic [WORD_W:0]   limit);
        return ({1'b0, base} + {1'b0, len}) > limit;
    endfunction

endpackage

// File: rtl/io_mem_loader.sv
// IO-side DMA stage: loads a byte stream into memory words, or dumps words as bytes.
// Every output is a register; the combinational block computes their next values.
module io_mem_loader
    import io_mem_loader_pkg::*;
#(
    parameter int MEM_SIZE = 200
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START_LOAD,
    input  logic              START_DUMP,
    input  logic [WORD_W-1:0] BASE,
    input  logic [WORD_W-1:0] LEN,
    input  logic [BYTE_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic [BYTE_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic [WORD_W-1:0] RADDR_IO,
    input  logic [WORD_W-1:0] DATA_OUT_IO,
    output logic [WORD_W-1:0] WADDR_IO,
    output logic [WORD_W-1:0] DATA_IN_IO,
    output logic              MW_IO_ON,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam logic [WORD_W:0] LIMIT = (WORD_W+1)'(MEM_SIZE);

    state_t            state, state_n;
    logic [WORD_W-1:0] addr, addr_n;
    logic [WORD_W-1:0] remaining, remaining_n;
    logic [WORD_W-1:0] word, word_n;

    logic              rx_ready_n, tx_valid_n, mw_n, busy_n, done_n, err_n;
    logic [BYTE_W-1:0] tx_data_n;
    logic [WORD_W-1:0] raddr_n, waddr_n, data_in_n;

    logic rx_fire, tx_fire, last_word;

    assign rx_fire   = RX_VALID && RX_READY;
    assign tx_fire   = TX_VALID && TX_READY;
    assign last_word = (remaining == WORD_W'(1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            word       <= '0;
            RX_READY   <= 1'b0;
            TX_VALID   <= 1'b0;
            TX_DATA    <= '0;
            RADDR_IO   <= '0;
            WADDR_IO   <= '0;
            DATA_IN_IO <= '0;
            MW_IO_ON   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            remaining  <= remaining_n;
            word       <= word_n;
            RX_READY   <= rx_ready_n;
            TX_VALID   <= tx_valid_n;
            TX_DATA    <= tx_data_n;
            RADDR_IO   <= raddr_n;
            WADDR_IO   <= waddr_n;
            DATA_IN_IO <= data_in_n;
            MW_IO_ON   <= mw_n;
            BUSY       <= busy_n;
            DONE       <= done_n;
            ERR        <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        word_n      = word;
        rx_ready_n  = RX_READY;
        tx_valid_n  = TX_VALID;
        tx_data_n   = TX_DATA;
        raddr_n     = RADDR_IO;
        waddr_n     = WADDR_IO;
        data_in_n   = DATA_IN_IO;
        mw_n        = 1'b0;
        busy_n      = BUSY;
        done_n      = 1'b0;
        err_n       = 1'b0;

        case (state)
            IDLE: begin
                if (START_LOAD || START_DUMP) begin
                    addr_n      = BASE;
                    remaining_n = LEN;
                    if (range_bad(BASE, LEN, LIMIT)) begin
                        err_n = 1'b1;
                    end else if (LEN == '0) begin
                        state_n = FIN;
                        done_n  = 1'b1;
                    end else if (START_LOAD) begin
                        state_n    = LD_HI;
                        rx_ready_n = 1'b1;
                        busy_n     = 1'b1;
                    end else begin
                        state_n = DP_RD;
                        raddr_n = BASE;
                        busy_n  = 1'b1;
                    end
                end
            end

            LD_HI: begin
                if (rx_fire) begin
                    word_n[WORD_W-1:BYTE_W] = RX_DATA;
                    state_n                 = LD_LO;
                end
            end

            // Write strobe and address are registered here so they are
            // already stable when the memory captures on the falling edge.
            LD_LO: begin
                if (rx_fire) begin
                    word_n[BYTE_W-1:0] = RX_DATA;
                    state_n            = LD_WR;
                    rx_ready_n         = 1'b0;
                    mw_n               = 1'b1;
                    waddr_n            = addr;
                    data_in_n          = {word[WORD_W-1:BYTE_W], RX_DATA};
                end
            end

            LD_WR: begin
                addr_n      = addr + WORD_W'(1);
                remaining_n = remaining - WORD_W'(1);
                if (last_word) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    state_n    = LD_HI;
                    rx_ready_n = 1'b1;
                end
            end

            DP_RD: begin
                word_n     = DATA_OUT_IO;
                tx_data_n  = DATA_OUT_IO[WORD_W-1:BYTE_W];
                tx_valid_n = 1'b1;
                state_n    = DP_HI;
            end

            DP_HI: begin
                if (tx_fire) begin
                    tx_data_n = word[BYTE_W-1:0];
                    state_n   = DP_LO;
                end
            end

            DP_LO: begin
                if (tx_fire) begin
                    addr_n      = addr + WORD_W'(1);
                    remaining_n = remaining - WORD_W'(1);
                    tx_valid_n  = 1'b0;
                    if (last_word) begin
                        state_n = FIN;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = DP_RD;
                        raddr_n = addr + WORD_W'(1);
                    end
                end
            end

            FIN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_io_mem_loader.sv
// Scoreboard bench for io_mem_loader: stimulus pushes expected writes, bytes and
// events into queues; a falling-edge monitor pops and compares them.
module tb_io_mem_loader;

    logic        CLK, RST, START_LOAD, START_DUMP;
    logic [15:0] BASE, LEN;
    logic [7:0]  RX_DATA;
    logic        RX_VALID, RX_READY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID, TX_READY;
    logic [15:0] RADDR_IO, DATA_OUT_IO, WADDR_IO, DATA_IN_IO;
    logic        MW_IO_ON, BUSY, DONE, ERR;

    io_mem_loader #(.MEM_SIZE(200)) dut (
        .CLK(CLK), .RST(RST), .START_LOAD(START_LOAD), .START_DUMP(START_DUMP),
        .BASE(BASE), .LEN(LEN), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .RADDR_IO(RADDR_IO), .DATA_OUT_IO(DATA_OUT_IO),
        .WADDR_IO(WADDR_IO), .DATA_IN_IO(DATA_IN_IO), .MW_IO_ON(MW_IO_ON),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before timeout");
        $fatal(1);
    end

    // Memory model: combinational read, write on the falling edge.
    logic [15:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 16'hE000 | 16'(i);
    assign DATA_OUT_IO = mem[RADDR_IO[7:0]];
    always @(negedge CLK) if (MW_IO_ON) mem[WADDR_IO[7:0]] <= DATA_IN_IO;

    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;

    logic [31:0] exp_wr [$];
    logic [7:0]  exp_tx [$];
    logic [1:0]  exp_ev [$];
    logic [7:0]  rx_bytes [$];

    int n_checks = 0, n_pass = 0;
    int mw_cycles = 0, rx_ready_cycles = 0, busy_cycles = 0, done_cycles = 0;
    bit          hold_pend = 0;
    logic [7:0]  hold_data = 8'h00;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endfunction

    function automatic void fail(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got %0h, required nothing", name, act);
    endfunction

    function automatic logic [63:0] out_vec();
        return {2'b00, RX_READY, TX_VALID, TX_DATA, RADDR_IO, WADDR_IO, DATA_IN_IO,
                MW_IO_ON, BUSY, DONE, ERR};
    endfunction

    // Monitor: compares every write, TX transfer and DONE/ERR pulse with the queues.
    always @(negedge CLK) begin
        if (RST) begin
            hold_pend = 0;
        end else begin
            if (MW_IO_ON) begin
                mw_cycles++;
                if (exp_wr.size() == 0) fail("unexpected_write", {32'h0, WADDR_IO, DATA_IN_IO});
                else check("mem_write", {32'h0, WADDR_IO, DATA_IN_IO}, {32'h0, exp_wr.pop_front()});
            end
            if (hold_pend) check("tx_hold", {55'h0, TX_VALID, TX_DATA}, {55'h0, 1'b1, hold_data});
            if (TX_VALID && TX_READY) begin
                if (exp_tx.size() == 0) fail("unexpected_tx", {56'h0, TX_DATA});
                else check("tx_byte", {56'h0, TX_DATA}, {56'h0, exp_tx.pop_front()});
            end
            hold_pend = TX_VALID && !TX_READY;
            hold_data = TX_DATA;
            if (DONE) begin
                done_cycles++;
                if (exp_ev.size() == 0) fail("unexpected_done", 64'h1);
                else check("event_done", {62'h0, EV_DONE}, {62'h0, exp_ev.pop_front()});
            end
            if (ERR) begin
                if (exp_ev.size() == 0) fail("unexpected_err", 64'h1);
                else check("event_err", {62'h0, EV_ERR}, {62'h0, exp_ev.pop_front()});
            end
            if (RX_READY) rx_ready_cycles++;
            if (BUSY) busy_cycles++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drives one start, feeds rx_bytes with optional gaps, optionally toggles
    // TX_READY, and ends on DONE/ERR, after stop_wr writes, or at the budget.
    task automatic run_xfer(input bit ld, input bit dp, input logic [15:0] base,
                            input logic [15:0] len, input int gap, input bit tx_toggle,
                            input int stop_wr, input int busy_dump_at, input int budget,
                            output int lat);
        int idx, g, cyc, mw0;
        logic fire;
        bit seen;
        idx = 0; g = 0; cyc = 0; seen = 0; mw0 = mw_cycles;
        START_LOAD = ld; START_DUMP = dp; BASE = base; LEN = len;
        RX_VALID = (gap == 0) && (rx_bytes.size() > 0);
        RX_DATA  = (rx_bytes.size() > 0) ? rx_bytes[0] : 8'h00;
        TX_READY = 1'b1;
        while (!seen && cyc < budget) begin
            fire = RX_VALID && RX_READY;
            tick();
            cyc++;
            START_LOAD = 1'b0;
            START_DUMP = (cyc == busy_dump_at);
            if (fire) begin
                idx++;
                g = 0;
            end else if (!RX_VALID) begin
                g++;
            end
            RX_VALID = (idx < rx_bytes.size()) && (g >= gap);
            RX_DATA  = (idx < rx_bytes.size()) ? rx_bytes[idx] : 8'h00;
            TX_READY = tx_toggle ? ~TX_READY : 1'b1;
            if (DONE || ERR) seen = 1;
            if (stop_wr > 0 && (mw_cycles - mw0) >= stop_wr) break;
        end
        START_DUMP = 1'b0;
        RX_VALID   = 1'b0;
        lat = seen ? cyc : -1;
    endtask

    initial begin
        int lat, mw0, bz0, rr0, dn0;
        RST = 1'b1; START_LOAD = 0; START_DUMP = 0; BASE = 0; LEN = 0;
        RX_DATA = 0; RX_VALID = 0; TX_READY = 0;
        idle(2);
        check("reset_outputs", out_vec(), 64'h0);
        RST = 1'b0;
        idle(1);

        // LOAD 10/2, back-to-back bytes: 3 cycles per word.
        rx_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        exp_wr.push_back({16'd10, 16'h1234});
        exp_wr.push_back({16'd11, 16'hABCD});
        exp_ev.push_back(EV_DONE);
        mw0 = mw_cycles; bz0 = busy_cycles;
        run_xfer(1, 0, 16'd10, 16'd2, 0, 0, 0, -1, 50, lat);
        idle(2);
        check("load_latency", 64'(lat), 64'd7);
        check("load_mw_cycles", 64'(mw_cycles - mw0), 64'd2);
        check("load_busy_cycles", 64'(busy_cycles - bz0), 64'd6);
        check("mem10", {48'h0, mem[10]}, {48'h0, 16'h1234});
        check("mem11", {48'h0, mem[11]}, {48'h0, 16'hABCD});

        // DUMP 10/2 with TX_READY toggling.
        rx_bytes.delete();
        exp_tx = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        exp_ev.push_back(EV_DONE);
        dn0 = done_cycles;
        run_xfer(0, 1, 16'd10, 16'd2, 0, 1, 0, -1, 60, lat);
        idle(2);
        check("dump_done_once", 64'(done_cycles - dn0), 64'd1);

        // Out of range: 199+2 > 200.
        exp_ev.push_back(EV_ERR);
        mw0 = mw_cycles; bz0 = busy_cycles;
        run_xfer(1, 0, 16'd199, 16'd2, 0, 0, 0, -1, 10, lat);
        idle(3);
        check("err_latency", 64'(lat), 64'd1);
        check("err_busy_cycles", 64'(busy_cycles - bz0), 64'd0);
        check("err_mw_cycles", 64'(mw_cycles - mw0), 64'd0);

        // Upper boundary: 198+2 == 200 is accepted.
        rx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_wr.push_back({16'd198, 16'h0102});
        exp_wr.push_back({16'd199, 16'h0304});
        exp_ev.push_back(EV_DONE);
        run_xfer(1, 0, 16'd198, 16'd2, 0, 0, 0, -1, 50, lat);
        idle(2);
        check("edge_latency", 64'(lat), 64'd7);
        check("mem199", {48'h0, mem[199]}, {48'h0, 16'h0304});

        // LEN == 0.
        rx_bytes.delete();
        exp_ev.push_back(EV_DONE);
        rr0 = rx_ready_cycles; mw0 = mw_cycles;
        run_xfer(1, 0, 16'd5, 16'd0, 0, 0, 0, -1, 10, lat);
        idle(2);
        check("len0_done_soon", 64'(lat >= 1 && lat <= 2), 64'd1);
        check("len0_rx_ready", 64'(rx_ready_cycles - rr0), 64'd0);
        check("len0_mw_cycles", 64'(mw_cycles - mw0), 64'd0);

        // Simultaneous starts: LOAD wins, no TX traffic.
        rx_bytes = '{8'h77, 8'h88};
        exp_wr.push_back({16'd30, 16'h7788});
        exp_ev.push_back(EV_DONE);
        mw0 = mw_cycles;
        run_xfer(1, 1, 16'd30, 16'd1, 0, 0, 0, -1, 30, lat);
        idle(2);
        check("both_mw_cycles", 64'(mw_cycles - mw0), 64'd1);
        check("mem30", {48'h0, mem[30]}, {48'h0, 16'h7788});

        // Gapped RX with a START_DUMP while busy.
        rx_bytes = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        exp_wr.push_back({16'd40, 16'h9ABC});
        exp_wr.push_back({16'd41, 16'hDEF0});
        exp_ev.push_back(EV_DONE);
        dn0 = done_cycles;
        run_xfer(1, 0, 16'd40, 16'd2, 5, 0, 0, 3, 100, lat);
        idle(3);
        check("gap_done_seen", 64'(lat > 0), 64'd1);
        check("gap_done_once", 64'(done_cycles - dn0), 64'd1);
        check("mem40", {48'h0, mem[40]}, {48'h0, 16'h9ABC});
        check("mem41", {48'h0, mem[41]}, {48'h0, 16'hDEF0});

        // DUMP 198/2 with TX_READY high: 3 cycles per word.
        rx_bytes.delete();
        exp_tx = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_ev.push_back(EV_DONE);
        run_xfer(0, 1, 16'd198, 16'd2, 0, 0, 0, -1, 50, lat);
        idle(2);
        check("dump_latency", 64'(lat), 64'd7);

        // Reset after the first word of a two-word LOAD.
        rx_bytes = '{8'h5A, 8'hA5, 8'h3C};
        exp_wr.push_back({16'd20, 16'h5AA5});
        mw0 = mw_cycles;
        run_xfer(1, 0, 16'd20, 16'd2, 0, 0, 1, -1, 30, lat);
        RST = 1'b1;
        tick();
        check("midreset_outputs", out_vec(), 64'h0);
        RST = 1'b0;
        idle(4);
        check("midreset_mw_cycles", 64'(mw_cycles - mw0), 64'd1);
        check("mem20_kept", {48'h0, mem[20]}, {48'h0, 16'h5AA5});
        check("mem21_untouched", {48'h0, mem[21]}, {48'h0, 16'hE015});
        check("idle_after_reset", out_vec() & 64'h1_0000_0000_000F, 64'h0);

        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
        check("ev_queue_drained", 64'(exp_ev.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
